// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch (IF) and load/store (D), with D priority, starvation bound and timeout.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_D_RUN = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall,
  output logic              err
);
  localparam int RW = $clog2(MAX_D_RUN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_D_RUN);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            state, state_nxt;
  logic [RW-1:0]     run_cnt, run_nxt;
  logic [TW-1:0]     to_cnt, to_nxt;
  logic              if_pend, d_pend, grant_d, grant_i, done, abort;
  logic              mem_req_nxt, mem_we_nxt, if_ack_nxt, d_ack_nxt, err_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;

  // A requester sitting in its ack cycle still holds req; it must not re-win.
  assign if_pend = if_req & ~if_ack;
  assign d_pend  = d_req & ~d_ack;
  assign stall   = if_pend | d_pend;

  assign grant_d = (state == IDLE) & d_pend & ~(if_pend & (run_cnt == RUN_MAX));
  assign grant_i = (state == IDLE) & if_pend & ~grant_d;
  assign done    = (state != IDLE) & mem_ready;
  assign abort   = (state != IDLE) & ~mem_ready & (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      run_cnt   <= '0;
      to_cnt    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_nxt;
      to_cnt    <= to_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      if_ack    <= if_ack_nxt;
      d_ack     <= d_ack_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      default: if (done | abort) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    d_rdata_nxt   = d_rdata;
    if_ack_nxt    = 1'b0;
    d_ack_nxt     = 1'b0;
    err_nxt       = 1'b0;
    run_nxt       = run_cnt;
    to_nxt        = to_cnt;
    if (grant_d | grant_i) begin
      mem_req_nxt   = 1'b1;
      mem_we_nxt    = grant_d & d_we;
      mem_addr_nxt  = grant_d ? d_addr : if_addr;
      mem_wdata_nxt = grant_d ? d_wdata : '0;
      to_nxt        = '0;
      // Count only D wins that actually made IF wait; saturate at the bound.
      if (grant_i | ~if_req)      run_nxt = '0;
      else if (run_cnt != RUN_MAX) run_nxt = run_cnt + 1'b1;
    end else if (state != IDLE) begin
      if (done | abort) begin
        mem_req_nxt = 1'b0;
        err_nxt     = abort;
        if (state == BUSY_I) begin
          if_ack_nxt   = 1'b1;
          if_rdata_nxt = done ? mem_rdata : '0;
        end else begin
          d_ack_nxt = 1'b1;
          if (abort)        d_rdata_nxt = '0;
          else if (!mem_we) d_rdata_nxt = mem_rdata;
        end
      end else begin
        to_nxt = to_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter; a transaction-level
// reference model predicts every registered output cycle by cycle.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MAXR = 4, TO = 255;

  logic          clk = 1'b0, rst = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_ack, d_ack, mem_req, mem_we, stall, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall), .err(err)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: owner 0 = none, 1 = IF, 2 = D
  int            m_own = 0, m_run = 0, m_wait = 0;
  logic          e_req = 0, e_we = 0, e_iack = 0, e_dack = 0, e_err = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_irdata = '0, e_drdata = '0;

  // stimulus knobs
  bit rnd_on = 0, rnd_lat = 0;
  int fixed_wait = 0, mcnt = 0, mwait = 0, req_cyc = 0;

  task automatic model_reset();
    m_own = 0; m_run = 0; m_wait = 0;
    e_req = 0; e_we = 0; e_iack = 0; e_dack = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
  endtask

  task automatic model_finish(input bit ok);
    e_req = 0;
    e_err = !ok;
    if (m_own == 1) begin
      e_iack = 1; e_irdata = ok ? mem_rdata : '0;
    end else begin
      e_dack = 1;
      if (!ok) e_drdata = '0;
      else if (!e_we) e_drdata = mem_rdata;
    end
    m_own = 0;
  endtask

  task automatic model_edge();
    bit pi, pd;
    pi = if_req && !e_iack;
    pd = d_req && !e_dack;
    e_iack = 0; e_dack = 0; e_err = 0;
    if (m_own == 0) begin
      if (pd && !(pi && m_run == MAXR)) begin
        m_own = 2; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        m_run = if_req ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
      end else if (pi) begin
        m_own = 1; e_we = 0; e_addr = if_addr; m_run = 0;
      end
      if (m_own != 0) begin e_req = 1; m_wait = 0; end
    end else if (mem_ready) begin
      model_finish(1);
    end else begin
      m_wait++;
      if (m_wait == TO) model_finish(0);
    end
  endtask

  // one clock: called and returns at a falling edge
  task automatic cycle();
    chk("mem_req", mem_req, e_req);
    if (e_req) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", mem_we, e_we);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("if_ack", if_ack, e_iack);
    chk("d_ack", d_ack, e_dack);
    chk("err", err, e_err);
    chk("if_rdata", if_rdata, e_irdata);
    chk("d_rdata", d_rdata, e_drdata);
    if (mem_req) req_cyc++;
    if (if_req && if_ack) if_req = 0;
    if (d_req && d_ack) d_req = 0;
    if (rnd_on) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin if_req = 1; if_addr = $urandom; end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = $urandom_range(0, 1) == 1; d_addr = $urandom; d_wdata = $urandom;
      end
      // fields may wander after the grant; only the grant-edge values matter
      if ($urandom_range(0, 7) == 0) if_addr = $urandom;
      if ($urandom_range(0, 7) == 0) begin d_addr = $urandom; d_wdata = $urandom; end
    end
    if (mem_req) begin
      mcnt++;
      mem_ready = (mcnt > mwait);
    end else begin
      mcnt = 0;
      mwait = rnd_lat ? $urandom_range(0, 3) : fixed_wait;
      mem_ready = ($urandom_range(0, 7) == 0);
    end
    mem_rdata = rnd_lat ? $urandom : 32'hE3A01005;
    #1;
    chk("stall", stall, (if_req && !e_iack) || (d_req && !e_dack));
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int lat, td, ti;
    logic [DW-1:0] prev;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_acks", {if_ack, d_ack, err}, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    chk("rst_stall", stall, 0);
    rst = 1;
    model_reset();
    repeat (2) cycle();

    // single IF read, ready on 3rd mem_req cycle
    fixed_wait = 2;
    if_req = 1; if_addr = 32'h100;
    lat = 0; req_cyc = 0;
    while (!if_ack && lat < 20) begin cycle(); lat++; end
    chk("t1_lat", lat, 4);
    chk("t1_reqcyc", req_cyc, 3);
    chk("t1_rdata", if_rdata, 32'hE3A01005);
    repeat (2) cycle();

    // simultaneous IF and D load, zero-wait memory
    fixed_wait = 0;
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h200;
    td = -1; ti = -1;
    for (int k = 0; k < 12; k++) begin
      if (d_ack && td < 0) td = k;
      if (if_ack && ti < 0) ti = k;
      cycle();
    end
    chk("t2_d_first", (td >= 0) && (td < ti), 1);
    chk("t2_gap", ti - td, 2);

    // store
    fixed_wait = 1;
    prev = e_drdata;
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
    lat = 0;
    while (!mem_req && lat < 10) begin cycle(); lat++; end
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 32'h40);
    chk("t3_wdata", mem_wdata, 32'hDEADBEEF);
    lat = 0;
    while (!d_ack && lat < 10) begin cycle(); lat++; end
    chk("t3_ack", d_ack, 1);
    chk("t3_rdata_hold", d_rdata, prev);
    repeat (2) cycle();

    // timeout
    fixed_wait = 1000;
    d_req = 1; d_we = 0; d_addr = 32'h80;
    lat = 0; req_cyc = 0;
    while (!err && lat < 400) begin cycle(); lat++; end
    chk("to_reqcyc", req_cyc, TO);
    chk("to_err", err, 1);
    chk("to_dack", d_ack, 1);
    chk("to_rdata", d_rdata, 0);
    cycle();
    chk("to_err_pulse", err, 0);
    cycle();

    // reset one cycle into BUSY_D
    fixed_wait = 5;
    d_req = 1; d_we = 0; d_addr = 32'h44;
    lat = 0;
    while (!mem_req && lat < 10) begin cycle(); lat++; end
    cycle();
    rst = 0;
    #1;
    chk("mr_mem_req", mem_req, 0);
    chk("mr_acks", {if_ack, d_ack, err}, 0);
    d_req = 0;
    model_reset();
    @(negedge clk);
    rst = 1;
    fixed_wait = 1;
    if_req = 1; if_addr = 32'h104;
    lat = 0;
    while (!if_ack && lat < 10) begin cycle(); lat++; end
    chk("mr_if_lat", lat, 3);
    repeat (2) cycle();

    // randomized traffic
    rnd_on = 1; rnd_lat = 1;
    repeat (3000) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
